// File: rtl/ifu_ifetch_pkg.sv
// Shared types and constants for the IFU fetch controller.
// State encodings are 2 bits; HALT is only reachable when IFU_MISALIGN_CHK_EN is defined.
package ifu_ifetch_pkg;

  localparam int PC_SIZE     = 32;
  localparam int INSTR_SIZE  = 32;
  localparam int RFIDX_WIDTH = 5;

  localparam logic [PC_SIZE-1:0] PC_INCR = PC_SIZE'(4);

  typedef enum logic [1:0] {
    IFETCH_ST_IDLE = 2'd0,
    IFETCH_ST_REQ  = 2'd1,
    IFETCH_ST_WAIT = 2'd2,
    IFETCH_ST_HALT = 2'd3
  } ifetch_state_e;

  // PC arithmetic wraps modulo 2^PC_SIZE
  function automatic logic [PC_SIZE-1:0] pc_add(input logic [PC_SIZE-1:0] a,
                                                input logic [PC_SIZE-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/ifu_ifetch_ir.sv
// Instruction register of the fetch unit: holds the last fetched instruction,
// its PC and fault flags, the valid/clear handshake towards EXU, and the
// rd-index compare the BPU uses to detect a JALR rs1 dependency on IR.
module ifu_ifetch_ir
  import ifu_ifetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ir_load,
  input  logic                   ir_flush,
  input  logic [INSTR_SIZE-1:0]  load_instr,
  input  logic [PC_SIZE-1:0]     load_pc,
  input  logic                   load_err,
  input  logic                   load_misalgn,
  input  logic                   load_rs1en,
  input  logic                   load_rden,
  input  logic [RFIDX_WIDTH-1:0] load_rdidx,
  input  logic                   ir_ready,
  input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
  output logic                   ir_valid,
  output logic [INSTR_SIZE-1:0]  ir_instr,
  output logic [PC_SIZE-1:0]     ir_pc,
  output logic                   ir_err,
  output logic                   ir_misalgn,
  output logic                   ir_rs1en,
  output logic                   ir_empty,
  output logic                   ir_valid_clr,
  output logic                   jalr_rs1idx_cam_irrdidx
);

  logic                   ir_valid_q,   ir_valid_d;
  logic [INSTR_SIZE-1:0]  ir_instr_q,   ir_instr_d;
  logic [PC_SIZE-1:0]     ir_pc_q,      ir_pc_d;
  logic                   ir_err_q,     ir_err_d;
  logic                   ir_misalgn_q, ir_misalgn_d;
  logic                   ir_rs1en_q,   ir_rs1en_d;
  logic                   ir_rden_q,    ir_rden_d;
  logic [RFIDX_WIDTH-1:0] ir_rdidx_q,   ir_rdidx_d;

  // Flush kills IR; a new load wins over an EXU consume in the same cycle
  always_comb begin
    ir_valid_d   = ir_valid_q;
    ir_instr_d   = ir_instr_q;
    ir_pc_d      = ir_pc_q;
    ir_err_d     = ir_err_q;
    ir_misalgn_d = ir_misalgn_q;
    ir_rs1en_d   = ir_rs1en_q;
    ir_rden_d    = ir_rden_q;
    ir_rdidx_d   = ir_rdidx_q;
    if (ir_flush) begin
      ir_valid_d = 1'b0;
    end else if (ir_load) begin
      ir_valid_d   = 1'b1;
      ir_instr_d   = load_instr;
      ir_pc_d      = load_pc;
      ir_err_d     = load_err;
      ir_misalgn_d = load_misalgn;
      ir_rs1en_d   = load_rs1en;
      ir_rden_d    = load_rden;
      ir_rdidx_d   = load_rdidx;
    end else if (ir_ready) begin
      ir_valid_d = 1'b0;
    end
  end

  // IR state flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_valid_q   <= 1'b0;
      ir_instr_q   <= '0;
      ir_pc_q      <= '0;
      ir_err_q     <= 1'b0;
      ir_misalgn_q <= 1'b0;
      ir_rs1en_q   <= 1'b0;
      ir_rden_q    <= 1'b0;
      ir_rdidx_q   <= '0;
    end else begin
      ir_valid_q   <= ir_valid_d;
      ir_instr_q   <= ir_instr_d;
      ir_pc_q      <= ir_pc_d;
      ir_err_q     <= ir_err_d;
      ir_misalgn_q <= ir_misalgn_d;
      ir_rs1en_q   <= ir_rs1en_d;
      ir_rden_q    <= ir_rden_d;
      ir_rdidx_q   <= ir_rdidx_d;
    end
  end

  assign ir_valid                = ir_valid_q;
  assign ir_instr                = ir_instr_q;
  assign ir_pc                   = ir_pc_q;
  assign ir_err                  = ir_err_q;
  assign ir_misalgn              = ir_misalgn_q;
  assign ir_rs1en                = ir_rs1en_q;
  assign ir_empty                = ~ir_valid_q;
  assign ir_valid_clr            = ir_valid_q & ir_ready;
  assign jalr_rs1idx_cam_irrdidx = ir_valid_q & ir_rden_q & (ir_rdidx_q == dec_jalr_rs1idx);

endmodule

// File: rtl/ifu_ifetch.sv
// IFU fetch controller: PC register, request/response FSM, next-PC selection
// from the BPU prediction, and pipeline-flush handling with stale-response drop.
// Optional build macro IFU_MISALIGN_CHK_EN: a misaligned next PC is not fetched;
// instead a misaligned-fault IR entry is produced and the FSM halts until a flush.
module ifu_ifetch
  import ifu_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ifu_req_valid,
  input  logic                   ifu_req_ready,
  output logic [PC_SIZE-1:0]     ifu_req_pc,
  input  logic                   ifu_rsp_valid,
  output logic                   ifu_rsp_ready,
  input  logic [INSTR_SIZE-1:0]  ifu_rsp_instr,
  input  logic                   ifu_rsp_err,
  output logic [INSTR_SIZE-1:0]  ifu_fetch_instr,
  output logic [PC_SIZE-1:0]     ifu_fetch_pc,
  input  logic                   dec_rs1en,
  input  logic                   dec_rden,
  input  logic [RFIDX_WIDTH-1:0] dec_rdidx,
  input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
  input  logic                   prdt_taken,
  input  logic                   bpu_wait,
  input  logic [PC_SIZE-1:0]     prdt_pc_add_op1,
  input  logic [PC_SIZE-1:0]     prdt_pc_add_op2,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  output logic [INSTR_SIZE-1:0]  ir_instr,
  output logic [PC_SIZE-1:0]     ir_pc,
  output logic                   ir_err,
  output logic                   ir_misalgn,
  output logic                   ir_empty,
  output logic                   ir_rs1en,
  output logic                   ir_valid_clr,
  output logic                   jalr_rs1idx_cam_irrdidx,
  input  logic                   pipe_flush_req,
  input  logic [PC_SIZE-1:0]     pipe_flush_pc,
  output logic                   pipe_flush_ack
);

  ifetch_state_e          state_q, state_d;
  logic [PC_SIZE-1:0]     pc_q, pc_d;
  logic                   drop_q, drop_d;

  logic                   ir_free;
  logic                   rsp_accept;
  logic                   rsp_load;
  logic                   halt_load;
  logic                   ir_load;
  logic [PC_SIZE-1:0]     next_pc;

  logic [INSTR_SIZE-1:0]  load_instr;
  logic                   load_err;
  logic                   load_misalgn;
  logic                   load_rs1en;
  logic                   load_rden;
  logic [RFIDX_WIDTH-1:0] load_rdidx;

  assign ir_free        = ~ir_valid | ir_ready;
  assign next_pc        = (prdt_taken & ~ifu_rsp_err) ? pc_add(prdt_pc_add_op1, prdt_pc_add_op2)
                                                      : pc_add(pc_q, PC_INCR);
  assign pipe_flush_ack = 1'b1;
  assign ifu_fetch_instr = ifu_rsp_instr;
  assign ifu_fetch_pc    = pc_q;
  assign ifu_rsp_ready   = rsp_accept;

`ifdef IFU_MISALIGN_CHK_EN
  assign ifu_req_pc = pc_q;
`else
  assign ifu_req_pc = {pc_q[PC_SIZE-1:2], 2'b00};
`endif

  // State, PC and drop-pending registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IFETCH_ST_IDLE;
      pc_q    <= RESET_PC[PC_SIZE-1:0];
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  // Next state, next PC and drop flag; a flush overrides every other transition
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (pipe_flush_req) begin
      pc_d = pipe_flush_pc;
      if ((state_q == IFETCH_ST_WAIT) ||
          ((state_q == IFETCH_ST_REQ) && ifu_req_valid && ifu_req_ready)) begin
        drop_d  = 1'b1;
        state_d = IFETCH_ST_WAIT;
      end else begin
        state_d = IFETCH_ST_REQ;
      end
    end else begin
      unique case (state_q)
        IFETCH_ST_IDLE: state_d = IFETCH_ST_REQ;
        IFETCH_ST_REQ: begin
          if (halt_load) begin
            state_d = IFETCH_ST_HALT;
          end else if (ifu_req_valid && ifu_req_ready) begin
            state_d = IFETCH_ST_WAIT;
          end
        end
        IFETCH_ST_WAIT: begin
          if (rsp_accept) begin
            state_d = IFETCH_ST_REQ;
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              pc_d = next_pc;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Bus handshakes and IR load strobes; a response is never consumed under flush so the drop flag still owns it
  always_comb begin
    ifu_req_valid = 1'b0;
    rsp_accept    = 1'b0;
    halt_load     = 1'b0;
    unique case (state_q)
      IFETCH_ST_REQ: begin
`ifdef IFU_MISALIGN_CHK_EN
        if (pc_q[1:0] != 2'b00) begin
          halt_load = ir_free & ~pipe_flush_req;
        end else begin
          ifu_req_valid = 1'b1;
        end
`else
        ifu_req_valid = 1'b1;
`endif
      end
      IFETCH_ST_WAIT: begin
        rsp_accept = ifu_rsp_valid & ir_free & (drop_q | ~bpu_wait) & ~pipe_flush_req;
      end
      default: begin
        ifu_req_valid = 1'b0;
      end
    endcase
    rsp_load = rsp_accept & ~drop_q;
    ir_load  = rsp_load | halt_load;
  end

  // IR load data: bus response normally, a synthetic misaligned-fault entry when halting
  always_comb begin
    load_instr   = ifu_rsp_instr;
    load_err     = ifu_rsp_err;
    load_misalgn = 1'b0;
    load_rs1en   = dec_rs1en;
    load_rden    = dec_rden;
    load_rdidx   = dec_rdidx;
    if (halt_load) begin
      load_instr   = '0;
      load_err     = 1'b0;
      load_misalgn = 1'b1;
      load_rs1en   = 1'b0;
      load_rden    = 1'b0;
      load_rdidx   = '0;
    end
  end

  ifu_ifetch_ir u_ir (
    .clk                     (clk),
    .rst                     (rst),
    .ir_load                 (ir_load),
    .ir_flush                (pipe_flush_req),
    .load_instr              (load_instr),
    .load_pc                 (pc_q),
    .load_err                (load_err),
    .load_misalgn            (load_misalgn),
    .load_rs1en              (load_rs1en),
    .load_rden               (load_rden),
    .load_rdidx              (load_rdidx),
    .ir_ready                (ir_ready),
    .dec_jalr_rs1idx         (dec_jalr_rs1idx),
    .ir_valid                (ir_valid),
    .ir_instr                (ir_instr),
    .ir_pc                   (ir_pc),
    .ir_err                  (ir_err),
    .ir_misalgn              (ir_misalgn),
    .ir_rs1en                (ir_rs1en),
    .ir_empty                (ir_empty),
    .ir_valid_clr            (ir_valid_clr),
    .jalr_rs1idx_cam_irrdidx (jalr_rs1idx_cam_irrdidx)
  );

endmodule

// File: tb/tb_ifu_ifetch.sv
// Self-checking bench for ifu_ifetch (RESET_PC = 0x80). Fetched responses the
// IFU should keep are queued as expected IR contents and popped when IR loads.
module tb_ifu_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rsp_instr;
  logic        ifu_rsp_err;
  logic [31:0] ifu_fetch_instr, ifu_fetch_pc;
  logic        dec_rs1en, dec_rden;
  logic [4:0]  dec_rdidx, dec_jalr_rs1idx;
  logic        prdt_taken, bpu_wait;
  logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;
  logic        ir_valid, ir_ready;
  logic [31:0] ir_instr, ir_pc;
  logic        ir_err, ir_misalgn, ir_empty, ir_rs1en, ir_valid_clr, jalr_rs1idx_cam_irrdidx;
  logic        pipe_flush_req, pipe_flush_ack;
  logic [31:0] pipe_flush_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } ir_exp_t;

  ir_exp_t sb[$];

  ifu_ifetch #(.RESET_PC(32'h0000_0080)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
    .ifu_fetch_instr(ifu_fetch_instr), .ifu_fetch_pc(ifu_fetch_pc),
    .dec_rs1en(dec_rs1en), .dec_rden(dec_rden), .dec_rdidx(dec_rdidx),
    .dec_jalr_rs1idx(dec_jalr_rs1idx),
    .prdt_taken(prdt_taken), .bpu_wait(bpu_wait),
    .prdt_pc_add_op1(prdt_pc_add_op1), .prdt_pc_add_op2(prdt_pc_add_op2),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_instr(ir_instr), .ir_pc(ir_pc),
    .ir_err(ir_err), .ir_misalgn(ir_misalgn), .ir_empty(ir_empty), .ir_rs1en(ir_rs1en),
    .ir_valid_clr(ir_valid_clr), .jalr_rs1idx_cam_irrdidx(jalr_rs1idx_cam_irrdidx),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_pc(pipe_flush_pc), .pipe_flush_ack(pipe_flush_ack)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays the bus: accepts one request at exp_pc, then returns a response,
  // holding bpu_wait high for wait_cycles; checks the IR load against the queue
  task automatic serve_fetch(input logic [31:0] instr, input logic err, input logic taken,
                             input logic [31:0] op1, input logic [31:0] op2,
                             input int wait_cycles, input logic [31:0] exp_pc,
                             output int held);
    int guard;
    ir_exp_t e;
    ir_exp_t got;
    guard = 0;
    held  = 0;
    while (ifu_req_valid !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== exp_pc) begin
      errors++;
      $display("[TB] FAIL fetch_req got valid=%0b pc=%h want valid=1 pc=%h", ifu_req_valid, ifu_req_pc, exp_pc);
      return;
    end
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready   = 1'b0;
    ifu_rsp_valid   = 1'b1;
    ifu_rsp_instr   = instr;
    ifu_rsp_err     = err;
    prdt_taken      = taken;
    prdt_pc_add_op1 = op1;
    prdt_pc_add_op2 = op2;
    bpu_wait        = (wait_cycles > 0);
    #1;
    guard = 0;
    while (ifu_rsp_ready !== 1'b1 && guard < 20) begin
      held++;
      guard++;
      @(posedge clk);
      #1;
      if (held >= wait_cycles) bpu_wait = 1'b0;
      #1;
    end
    checks++;
    if (ifu_rsp_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rsp_accept_timeout got rsp_ready=%0b want 1", ifu_rsp_ready);
      ifu_rsp_valid = 1'b0;
      bpu_wait      = 1'b0;
      return;
    end
    e = '{instr: instr, pc: exp_pc, err: err};
    sb.push_back(e);
    @(posedge clk);
    #1;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_err   = 1'b0;
    prdt_taken    = 1'b0;
    bpu_wait      = 1'b0;
    got = sb.pop_front();
    checks++;
    if (ir_valid !== 1'b1 || ir_instr !== got.instr || ir_pc !== got.pc || ir_err !== got.err) begin
      errors++;
      $display("[TB] FAIL ir_load got v=%0b instr=%h pc=%h err=%0b want v=1 instr=%h pc=%h err=%0b",
               ir_valid, ir_instr, ir_pc, ir_err, got.instr, got.pc, got.err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (ifu_req_valid !== 1'b0 || ifu_rsp_ready !== 1'b0 || ir_valid !== 1'b0 || ir_misalgn !== 1'b0 ||
        ir_err !== 1'b0 || ir_valid_clr !== 1'b0 || jalr_rs1idx_cam_irrdidx !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got req_v=%0b rsp_r=%0b ir_v=%0b misalgn=%0b err=%0b clr=%0b cam=%0b want all 0",
               ifu_req_valid, ifu_rsp_ready, ir_valid, ir_misalgn, ir_err, ir_valid_clr, jalr_rs1idx_cam_irrdidx);
    end
    checks++;
    if (ir_empty !== 1'b1 || pipe_flush_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_high_outputs got ir_empty=%0b flush_ack=%0b want 1 1", ir_empty, pipe_flush_ack);
    end
    checks++;
    if (ifu_fetch_pc !== 32'h80) begin
      errors++;
      $display("[TB] FAIL reset_pc got %h want %h", ifu_fetch_pc, 32'h80);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ifu_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_req got %0b want 0", ifu_req_valid);
    end
    tick();
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h80) begin
      errors++;
      $display("[TB] FAIL first_req got v=%0b pc=%h want v=1 pc=%h", ifu_req_valid, ifu_req_pc, 32'h80);
    end
  endtask

  task automatic test_sequential();
    int held;
    serve_fetch(32'h0000_0013, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h80, held);
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h84) begin
      errors++;
      $display("[TB] FAIL seq_next_pc got v=%0b pc=%h want v=1 pc=%h", ifu_req_valid, ifu_req_pc, 32'h84);
    end
  endtask

  task automatic test_predict();
    int held;
    serve_fetch(32'h0000_006F, 1'b0, 1'b1, 32'h100, 32'hFFFF_FFF0, 0, 32'h84, held);
    checks++;
    if (ifu_req_pc !== 32'hF0) begin
      errors++;
      $display("[TB] FAIL prdt_next_pc got %h want %h", ifu_req_pc, 32'hF0);
    end
  endtask

  task automatic test_bpu_wait();
    int held;
    serve_fetch(32'h0050_0093, 1'b0, 1'b0, 32'h0, 32'h0, 3, 32'hF0, held);
    checks++;
    if (held !== 3) begin
      errors++;
      $display("[TB] FAIL bpu_wait_holdoff got %0d cycles want %0d", held, 3);
    end
    checks++;
    if (ifu_req_pc !== 32'hF4) begin
      errors++;
      $display("[TB] FAIL bpu_wait_next_pc got %h want %h", ifu_req_pc, 32'hF4);
    end
  endtask

  task automatic test_bus_err();
    int held;
    serve_fetch(32'hFFFF_FFFF, 1'b1, 1'b1, 32'h400, 32'h0, 0, 32'hF4, held);
    checks++;
    if (ifu_req_pc !== 32'hF8) begin
      errors++;
      $display("[TB] FAIL err_ignores_prdt got %h want %h", ifu_req_pc, 32'hF8);
    end
  endtask

  task automatic test_flush();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready  = 1'b0;
    pipe_flush_req = 1'b1;
    pipe_flush_pc  = 32'h200;
    tick();
    pipe_flush_req = 1'b0;
    checks++;
    if (ifu_fetch_pc !== 32'h200 || ifu_req_valid !== 1'b0 || ir_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_wait got pc=%h req_v=%0b ir_v=%0b want pc=%h req_v=0 ir_v=0",
               ifu_fetch_pc, ifu_req_valid, ir_valid, 32'h200);
    end
    ifu_rsp_valid = 1'b1;
    ifu_rsp_instr = 32'hDEAD_BEEF;
    bpu_wait      = 1'b1;
    #1;
    checks++;
    if (ifu_rsp_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stale_rsp_ready got %0b want 1", ifu_rsp_ready);
    end
    tick();
    ifu_rsp_valid = 1'b0;
    bpu_wait      = 1'b0;
    checks++;
    if (ir_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stale_dropped got ir_valid=%0b want 0", ir_valid);
    end
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h200) begin
      errors++;
      $display("[TB] FAIL flush_refetch got v=%0b pc=%h want v=1 pc=%h", ifu_req_valid, ifu_req_pc, 32'h200);
    end
  endtask

  task automatic test_cam_hold();
    int held;
    ir_ready  = 1'b0;
    dec_rs1en = 1'b1;
    dec_rden  = 1'b1;
    dec_rdidx = 5'd1;
    serve_fetch(32'h0010_8113, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h200, held);
    dec_rs1en       = 1'b0;
    dec_rden        = 1'b0;
    dec_rdidx       = 5'd0;
    dec_jalr_rs1idx = 5'd1;
    #1;
    checks++;
    if (jalr_rs1idx_cam_irrdidx !== 1'b1 || ir_empty !== 1'b0 || ir_rs1en !== 1'b1 || ir_valid_clr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cam_hit got cam=%0b empty=%0b rs1en=%0b clr=%0b want 1 0 1 0",
               jalr_rs1idx_cam_irrdidx, ir_empty, ir_rs1en, ir_valid_clr);
    end
    dec_jalr_rs1idx = 5'd2;
    #1;
    checks++;
    if (jalr_rs1idx_cam_irrdidx !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cam_miss got %0b want 0", jalr_rs1idx_cam_irrdidx);
    end
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_instr = 32'h0000_0513;
    tick();
    checks++;
    if (ifu_rsp_ready !== 1'b0 || ir_valid !== 1'b1 || ir_pc !== 32'h200) begin
      errors++;
      $display("[TB] FAIL ir_busy_holdoff got rsp_r=%0b ir_v=%0b ir_pc=%h want 0 1 %h",
               ifu_rsp_ready, ir_valid, ir_pc, 32'h200);
    end
    ir_ready = 1'b1;
    #1;
    checks++;
    if (ir_valid_clr !== 1'b1 || ifu_rsp_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ir_release got clr=%0b rsp_r=%0b want 1 1", ir_valid_clr, ifu_rsp_ready);
    end
    tick();
    ifu_rsp_valid = 1'b0;
    checks++;
    if (ir_valid !== 1'b1 || ir_pc !== 32'h204 || ir_instr !== 32'h0000_0513) begin
      errors++;
      $display("[TB] FAIL load_wins_clear got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
               ir_valid, ir_pc, ir_instr, 32'h204, 32'h0000_0513);
    end
  endtask

  task automatic test_wrap();
    int held;
    pipe_flush_req = 1'b1;
    pipe_flush_pc  = 32'hFFFF_FFFC;
    tick();
    pipe_flush_req = 1'b0;
    serve_fetch(32'h0000_0013, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'hFFFF_FFFC, held);
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL pc_wrap got v=%0b pc=%h want v=1 pc=%h", ifu_req_valid, ifu_req_pc, 32'h0);
    end
  endtask

  task automatic test_misalign();
    int held;
    serve_fetch(32'h0000_0067, 1'b0, 1'b1, 32'h100, 32'h2, 0, 32'h0, held);
`ifdef IFU_MISALIGN_CHK_EN
    checks++;
    if (ifu_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL misalign_no_req got %0b want 0", ifu_req_valid);
    end
    tick();
    checks++;
    if (ir_valid !== 1'b1 || ir_misalgn !== 1'b1 || ir_pc !== 32'h102) begin
      errors++;
      $display("[TB] FAIL misalign_ir got v=%0b misalgn=%0b pc=%h want 1 1 %h", ir_valid, ir_misalgn, ir_pc, 32'h102);
    end
    tick();
    checks++;
    if (ifu_req_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_no_req got %0b want 0", ifu_req_valid);
    end
    pipe_flush_req = 1'b1;
    pipe_flush_pc  = 32'h300;
    tick();
    pipe_flush_req = 1'b0;
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h300) begin
      errors++;
      $display("[TB] FAIL halt_exit got v=%0b pc=%h want v=1 pc=%h", ifu_req_valid, ifu_req_pc, 32'h300);
    end
`else
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h100 || ir_misalgn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL misalign_masked got v=%0b pc=%h misalgn=%0b want v=1 pc=%h misalgn=0",
               ifu_req_valid, ifu_req_pc, ir_misalgn, 32'h100);
    end
`endif
  endtask

  task automatic test_reset_midway();
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (ifu_fetch_pc !== 32'h80 || ifu_req_valid !== 1'b0 || ir_valid !== 1'b0 || ifu_rsp_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_midway got pc=%h req_v=%0b ir_v=%0b rsp_r=%0b want pc=%h 0 0 0",
               ifu_fetch_pc, ifu_req_valid, ir_valid, ifu_rsp_ready, 32'h80);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h80) begin
      errors++;
      $display("[TB] FAIL restart_req got v=%0b pc=%h want v=1 pc=%h", ifu_req_valid, ifu_req_pc, 32'h80);
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    ifu_req_ready   = 1'b0;
    ifu_rsp_valid   = 1'b0;
    ifu_rsp_instr   = '0;
    ifu_rsp_err     = 1'b0;
    dec_rs1en       = 1'b0;
    dec_rden        = 1'b0;
    dec_rdidx       = '0;
    dec_jalr_rs1idx = '0;
    prdt_taken      = 1'b0;
    bpu_wait        = 1'b0;
    prdt_pc_add_op1 = '0;
    prdt_pc_add_op2 = '0;
    ir_ready        = 1'b1;
    pipe_flush_req  = 1'b0;
    pipe_flush_pc   = '0;
    test_reset();
    test_sequential();
    test_predict();
    test_bpu_wait();
    test_bus_err();
    test_flush();
    test_cam_hold();
    test_wrap();
    test_misalign();
    test_reset_midway();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the scenario sequence stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
